// File: rtl/nibble_serial_pkg.sv
// nibble_serial_pkg: shared definitions for the nibble-serial adder controller.
//   state_t   - controller state encoding (2 bits; code 2'd3 is unused)
//   NIBBLE_W  - width of one nibble handed to the external adder
//   cnt_width - counter width needed to index NIB nibbles (clog2, minimum 1)
package nibble_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int cnt_width(input int nib);
    int w;
    w = 1;
    while ((1 << w) < nib) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_shift.sv
// nibble_shift_reg: WIDTH-bit register with parallel load, shift right by one
// nibble, and insertion of a new nibble at the MSB end.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears q)
//   load      - load load_val (has priority over shift)
//   load_val  - parallel load value
//   shift     - shift right by NIBBLE_W, inserting ins at the top
//   ins       - nibble inserted at the MSB on shift
//   q         - register contents
module nibble_shift_reg
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                shift,
  input  logic [NIBBLE_W-1:0] ins,
  output logic [WIDTH-1:0]    q
);

  // Storage: load wins over shift; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{1'b0}};
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {ins, q[WIDTH-1:NIBBLE_W]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder controller that drives an external
// 4-bit ripple-carry adder one nibble per clock, LSB nibble first.
// Optional feature macro: NIBBLE_SERIAL_ADDER_SUB_EN adds an op_sub input;
// when set at accept, the result is op_a - op_b (cout=1 means no borrow).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake (op_a, op_b, cin [, op_sub])
//   add_a/add_b/add_cin - nibble operands and carry to the external adder
//   add_sum/add_cout    - combinational response of the external adder
//   out_valid/out_ready - result handshake (result, cout)
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic                cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                op_sub,
`endif
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_cin,
  input  logic [NIBBLE_W-1:0] add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                cout
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic              carry_r;
  logic              load_s;
  logic              shift_s;
  logic [WIDTH-1:0]  b_load_s;
  logic              carry_load_s;
  logic [WIDTH-1:0]  a_q_s;
  logic [WIDTH-1:0]  b_q_s;
  logic [WIDTH-1:0]  res_q_s;
  // Only the low nibble of the operand shifters is ever observed.
  logic              unused_hi_s;

  assign unused_hi_s = ^{a_q_s[WIDTH-1:NIBBLE_W], b_q_s[WIDTH-1:NIBBLE_W]};
  assign load_s      = (state_r == IDLE) && in_valid;
  assign shift_s     = (state_r == RUN);

  // Operand preparation at accept: subtraction is A + ~B + 1.
  always_comb begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (op_sub) begin
      b_load_s     = ~op_b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = op_b;
      carry_load_s = cin;
    end
`else
    b_load_s     = op_b;
    carry_load_s = cin;
`endif
  end

  nibble_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (op_a),
    .shift    (shift_s),
    .ins      ({NIBBLE_W{1'b0}}),
    .q        (a_q_s)
  );

  nibble_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (b_load_s),
    .shift    (shift_s),
    .ins      ({NIBBLE_W{1'b0}}),
    .q        (b_q_s)
  );

  // Result fills from the top so that after NIB shifts nibble 0 sits at the LSB.
  nibble_shift_reg #(.WIDTH(WIDTH)) u_res_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val ({WIDTH{1'b0}}),
    .shift    (shift_s),
    .ins      (add_sum),
    .q        (res_q_s)
  );

  // Controller FSM: state, nibble counter and inter-nibble carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r <= RUN;
            cnt_r   <= {CW{1'b0}};
            carry_r <= carry_load_s;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          carry_r <= add_cout;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: adder operands only in RUN, result only in DONE.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
    if (state_r == RUN) begin
      add_a   = a_q_s[NIBBLE_W-1:0];
      add_b   = b_q_s[NIBBLE_W-1:0];
      add_cin = carry_r;
    end else begin
      add_a   = {NIBBLE_W{1'b0}};
      add_b   = {NIBBLE_W{1'b0}};
      add_cin = 1'b0;
    end
    if (state_r == DONE) begin
      result = res_q_s;
      cout   = carry_r;
    end else begin
      result = {WIDTH{1'b0}};
      cout   = 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder
// (WIDTH=16). Models the external 4-bit adder and checks hand-computed results.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic        op_sub;
`else
  logic        unused_sub;
`endif
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;

  int tests_run;
  int tests_failed;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op_sub    (op_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
  );

  // External 4-bit ripple-carry adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, run, optional backpressure hold, then drain.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sub, input logic [15:0] exp_res,
                       input logic exp_co, input logic [3:0] exp_cins, input int hold);
    int edges;
    int k;
    logic [3:0] cins;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    op_a = a;
    op_b = b;
    cin  = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub = sub;
`else
    unused_sub = sub;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = 16'hDEAD;
    op_b = 16'hBEEF;
    cin  = ~ci;
    check({tag, " in_ready run"}, 32'(in_ready), 32'd0);
    edges = 1;
    k = 0;
    cins = 4'd0;
    while (!out_valid && edges < 20) begin
      if (k < 4) cins[k] = add_cin;
      k++;
      tick();
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd5);
    check({tag, " add_cin seq"}, 32'(cins), 32'(exp_cins));
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " cout"}, 32'(cout), 32'(exp_co));
    check({tag, " add_a done"}, 32'(add_a), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      tick();
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold result"}, 32'(result), 32'(exp_res));
      check({tag, " hold cout"}, 32'(cout), 32'(exp_co));
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " drain valid"}, 32'(out_valid), 32'd0);
    check({tag, " drain in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 16'h0000;
    op_b      = 16'h0000;
    cin       = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub    = 1'b0;
`else
    unused_sub = 1'b0;
`endif
    tick();
    tick();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst add_a", 32'(add_a), 32'd0);
    check("rst add_b", 32'(add_b), 32'd0);
    check("rst add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    tick();

    // Basic adds, carry ripple and wrap-around.
    do_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 4'b0000, 0);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1110, 0);
    do_op("t3a", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b1111, 0);
    do_op("t3b", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0000, 0);

    // Backpressure with in_valid pulses while DONE.
    do_op("t4", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 4'b0000, 6);

    // Reset during the second RUN cycle.
    op_a = 16'hAAAA;
    op_b = 16'h5555;
    cin  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5 add_a run2", 32'(add_a), 32'hA);
    rst = 1'b1;
    #1;
    check("t5 rst out_valid", 32'(out_valid), 32'd0);
    check("t5 rst add_a", 32'(add_a), 32'd0);
    check("t5 rst add_b", 32'(add_b), 32'd0);
    check("t5 rst add_cin", 32'(add_cin), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t5 post in_ready", 32'(in_ready), 32'd1);
    check("t5 post out_valid", 32'(out_valid), 32'd0);
    do_op("t5", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 4'b0000, 0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Subtraction: cin is ignored, cout=1 means no borrow.
    do_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4'b0001, 0);
    do_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 4'b1111, 0);
    do_op("t6c", 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 4'b0001, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
